bcd_step_counter: RTL and testbench
===================================

Name: bcd_step_counter

Overview:
- Downstream consumer of the one-clock-period active-high press pulse produced by the pushbutton stage.
- Each pulse steps a multi-digit BCD counter up or down, with programmable modulo wrap-around.
- Drives registered active-low 7-segment patterns for the board HEX displays, plus a one-cycle wrap pulse for chaining.

Parameters:
- DIGITS, 2, number of BCD digits / HEX displays driven (1..4).
- MAX_COUNT, 99, terminal count in decimal; legal range 1..(10^DIGITS − 1). Values outside this range are a configuration error.
- BLANK_LEADING, 0, 1 = non-least-significant digits that are leading zeros show all segments off.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- step  input  1  one-cycle active-high count-enable pulse from the press stage.
- down  input  1  direction, sampled with step: 0 = increment, 1 = decrement.
- clear  input  1  synchronous clear to zero, active-high.
- bcd  output  4*DIGITS  current count, digit 0 in bits [3:0], each nibble 0..9.
- hex  output  7*DIGITS  segments per digit, active-low, bit0 = a … bit6 = g, digit 0 in bits [6:0].
- wrap  output  1  one-cycle pulse: counter wrapped MAX→0 (up) or 0→MAX (down).

Behaviour:
- Reset (reset = 0, asynchronous, any time including mid-count):
  - bcd = 0, wrap = 0.
  - hex digit 0 = 1000000 ("0").
  - Other hex digits = 1000000, or 1111111 when BLANK_LEADING = 1.
- Count is stored as per-digit BCD registers; no binary register and no binary-to-BCD conversion.
- Per-cycle priority: clear > step > hold.
  - clear = 1: bcd ← 0 next edge, wrap = 0 (even if step = 1 in the same cycle).
  - step = 1, down = 0:
    - bcd = MAX_COUNT → bcd ← 0, wrap = 1.
    - Otherwise, ripple increment: digit 9 → 0 with carry into the next digit.
  - step = 1, down = 1:
    - bcd = 0 → bcd ← MAX_COUNT, wrap = 1.
    - Otherwise, ripple decrement: digit 0 → 9 with borrow from the next digit.
  - step = 0: hold, wrap = 0.
- bcd and wrap update on the same edge. wrap is high for exactly one cycle per wrap event.
- step held high for N cycles produces N steps; no edge detection in this block.
- hex is registered from bcd: a change in bcd appears on hex one clock later (latency 1).
- Decode patterns (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Leading-zero blanking (BLANK_LEADING = 1):
  - Digit k (k ≥ 1) is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
- Illegal nibble values (>9) cannot occur; the decode default is all-off (1111111).

Test Plan:
- Reset, then 10 step pulses with down = 0 → bcd = 0x10, hex[13:0] = {1111001, 1000000} one cycle after the last bcd update, wrap never high.
- 100 up pulses from 0 (MAX_COUNT = 99) → bcd passes 0x99, then returns to 0x00; wrap high exactly once, in the cycle bcd becomes 0x00.
- From 0, one pulse with down = 1 → bcd = 0x99, wrap = 1 for one cycle; next down pulse → 0x98.
- bcd = 0x42, clear = 1 and step = 1 in the same cycle → bcd = 0x00, wrap = 0; hex shows "00" one cycle later.
- Drop reset to 0 between clock edges at bcd = 0x37 → bcd = 0 and hex = reset pattern immediately, without waiting for a clock edge; counting resumes correctly after release.
- DIGITS = 2, MAX_COUNT = 59, BLANK_LEADING = 1 → up from 0x59 wraps to 0x00; at bcd = 0x05, hex[13:7] = 1111111 and hex[6:0] = 0010010.

Source files
------------

// File: rtl/bcd_step_counter.sv
// Multi-digit BCD up/down step counter with programmable modulo wrap.
// Drives registered active-low 7-segment outputs and a one-cycle wrap pulse.
module bcd_step_counter #(
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned MAX_COUNT     = 99,
  parameter bit          BLANK_LEADING = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  down,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap
);

  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned HW    = 7 * DIGITS;
  localparam int unsigned LIMIT = (10 ** DIGITS) - 1;

  if ((DIGITS < 1) || (DIGITS > 4) || (MAX_COUNT < 1) || (MAX_COUNT > LIMIT)) begin : g_bad_cfg
    $error("bcd_step_counter: illegal DIGITS/MAX_COUNT configuration");
  end

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    int unsigned r;
    r      = v;
    to_bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(r % 10);
      r                = r / 10;
    end
  endfunction

  function automatic logic [HW-1:0] hex_reset();
    hex_reset = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      hex_reset[7*i +: 7] = (BLANK_LEADING && (i != 0)) ? 7'b1111111 : 7'b1000000;
    end
  endfunction

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  localparam logic [BW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
  localparam logic [HW-1:0] HEX_RST = hex_reset();

  logic [BW-1:0] bcd_inc;
  logic [BW-1:0] bcd_dec;
  logic [BW-1:0] bcd_nxt;
  logic [HW-1:0] hex_nxt;
  logic          wrap_nxt;
  logic          carry;
  logic          borrow;
  logic          upper_zero;
  logic [3:0]    nib;

  // Ripple increment and decrement directly on the BCD digits.
  always_comb begin
    bcd_inc = bcd;
    bcd_dec = bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    nib     = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (nib == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = nib - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // clear beats step beats hold; wrap only on a modulo boundary step.
  always_comb begin
    bcd_nxt  = bcd;
    wrap_nxt = 1'b0;
    if (clear) begin
      bcd_nxt = '0;
    end else if (step) begin
      if (down) begin
        if (bcd == '0) begin
          bcd_nxt  = MAX_BCD;
          wrap_nxt = 1'b1;
        end else begin
          bcd_nxt = bcd_dec;
        end
      end else begin
        if (bcd == MAX_BCD) begin
          bcd_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          bcd_nxt = bcd_inc;
        end
      end
    end
  end

  // Decode from the top digit down so leading-zero status accumulates.
  always_comb begin
    hex_nxt    = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (bcd[4*i +: 4] == 4'd0);
      if (BLANK_LEADING && (i != 0) && upper_zero) begin
        hex_nxt[7*i +: 7] = 7'b1111111;
      end else begin
        hex_nxt[7*i +: 7] = seg7(bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd  <= '0;
      wrap <= 1'b0;
      hex  <= HEX_RST;
    end else begin
      bcd  <= bcd_nxt;
      wrap <= wrap_nxt;
      hex  <= hex_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter: default 00..99 instance and a 00..59
// instance with leading-zero blanking.
module tb_bcd_step_counter;

  logic        clock;
  logic        reset;
  logic        step, down, clear;
  logic [7:0]  bcd;
  logic [13:0] hex;
  logic        wrap;
  logic        step2, down2, clear2;
  logic [7:0]  bcd2;
  logic [13:0] hex2;
  logic        wrap2;

  int tests;
  int fails;
  int wraps;

  bcd_step_counter dut (
    .clock (clock), .reset (reset), .step (step), .down (down), .clear (clear),
    .bcd (bcd), .hex (hex), .wrap (wrap)
  );

  bcd_step_counter #(.DIGITS(2), .MAX_COUNT(59), .BLANK_LEADING(1'b1)) dut59 (
    .clock (clock), .reset (reset), .step (step2), .down (down2), .clear (clear2),
    .bcd (bcd2), .hex (hex2), .wrap (wrap2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // step held high across n rising edges; returns at the negedge after the last.
  task automatic hold(input int n, input logic d);
    @(negedge clock);
    step = 1'b1;
    down = d;
    repeat (n) @(negedge clock);
    step = 1'b0;
    down = 1'b0;
  endtask

  task automatic hold2(input int n, input logic d);
    @(negedge clock);
    step2 = 1'b1;
    down2 = d;
    repeat (n) @(negedge clock);
    step2 = 1'b0;
    down2 = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; wraps = 0;
    reset = 1'b0;
    step = 1'b0; down = 1'b0; clear = 1'b0;
    step2 = 1'b0; down2 = 1'b0; clear2 = 1'b0;

    // Reset state
    #12;
    chk("rst_bcd", 32'(bcd), 32'h00);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_hex", 32'(hex), 32'(14'b1000000_1000000));
    chk("rst_hex_blank", 32'(hex2), 32'(14'b1111111_1000000));
    @(negedge clock);
    reset = 1'b1;

    // Ten up pulses
    for (int i = 0; i < 10; i++) begin
      hold(1, 1'b0);
      if (wrap) wraps++;
    end
    chk("up10_bcd", 32'(bcd), 32'h10);
    chk("up10_hex_lag", 32'(hex), 32'(14'b1000000_0010000));
    chk("up10_wraps", 32'(wraps), 32'd0);
    @(negedge clock);
    chk("up10_hex", 32'(hex), 32'(14'b1111001_1000000));

    // 100 up pulses from zero: full cycle with exactly one wrap
    do_clear();
    chk("clr_bcd", 32'(bcd), 32'h00);
    wraps = 0;
    for (int i = 1; i <= 100; i++) begin
      hold(1, 1'b0);
      chk("cyc_bcd", 32'(bcd), 32'((((i % 100) / 10) << 4) | ((i % 100) % 10)));
      chk("cyc_wrap", 32'(wrap), 32'(i == 100));
      if (wrap) wraps++;
    end
    chk("cyc_wraps", 32'(wraps), 32'd1);

    // step held high counts every cycle
    hold(3, 1'b0);
    chk("held3_bcd", 32'(bcd), 32'h03);

    // Down from zero wraps to MAX, then ordinary decrement
    do_clear();
    hold(1, 1'b1);
    chk("dn_wrap_bcd", 32'(bcd), 32'h99);
    chk("dn_wrap_pulse", 32'(wrap), 32'h1);
    @(negedge clock);
    chk("dn_wrap_oneshot", 32'(wrap), 32'h0);
    hold(1, 1'b1);
    chk("dn_98_bcd", 32'(bcd), 32'h98);
    chk("dn_98_wrap", 32'(wrap), 32'h0);

    // clear beats step in the same cycle
    do_clear();
    hold(42, 1'b0);
    chk("at42_bcd", 32'(bcd), 32'h42);
    @(negedge clock);
    clear = 1'b1;
    step  = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    step  = 1'b0;
    chk("clrstep_bcd", 32'(bcd), 32'h00);
    chk("clrstep_wrap", 32'(wrap), 32'h0);
    chk("clrstep_hex_lag", 32'(hex), 32'(14'b0011001_0100100));
    @(negedge clock);
    chk("clrstep_hex", 32'(hex), 32'(14'b1000000_1000000));

    // Asynchronous reset mid-count
    hold(37, 1'b0);
    chk("at37_bcd", 32'(bcd), 32'h37);
    @(negedge clock);
    chk("at37_hex", 32'(hex), 32'(14'b0110000_1111000));
    #2 reset = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd), 32'h00);
    chk("arst_hex", 32'(hex), 32'(14'b1000000_1000000));
    chk("arst_wrap", 32'(wrap), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    hold(1, 1'b0);
    chk("resume_up", 32'(bcd), 32'h01);
    hold(1, 1'b1);
    chk("resume_dn", 32'(bcd), 32'h00);
    chk("resume_wrap", 32'(wrap), 32'h0);

    // MAX_COUNT = 59 with leading-zero blanking
    hold2(59, 1'b0);
    chk("m59_bcd", 32'(bcd2), 32'h59);
    @(negedge clock);
    chk("m59_hex", 32'(hex2), 32'(14'b0010010_0010000));
    hold2(1, 1'b0);
    chk("m59_wrap_bcd", 32'(bcd2), 32'h00);
    chk("m59_wrap_pulse", 32'(wrap2), 32'h1);
    @(negedge clock);
    chk("m59_zero_hex", 32'(hex2), 32'(14'b1111111_1000000));
    hold2(1, 1'b1);
    chk("m59_dn_bcd", 32'(bcd2), 32'h59);
    chk("m59_dn_wrap", 32'(wrap2), 32'h1);
    @(negedge clock);
    clear2 = 1'b1;
    @(negedge clock);
    clear2 = 1'b0;
    hold2(5, 1'b0);
    chk("m59_05_bcd", 32'(bcd2), 32'h05);
    @(negedge clock);
    chk("m59_05_hex", 32'(hex2), 32'(14'b1111111_0010010));
    hold2(5, 1'b0);
    @(negedge clock);
    chk("m59_10_hex", 32'(hex2), 32'(14'b1111001_1000000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
